// File: rtl/cache_mem_burst_adapter_if.sv
// Cache-side line requests and single-word main-memory port of the burst adapter.
// The adapter takes the master view; the cache/memory environment takes the slave view.
interface cache_mem_burst_adapter_if #(
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32
);
  logic                             mem_read;
  logic                             mem_write;
  logic [ADDR_W-1:0]                line_addr;
  logic [WORDS_PER_LINE*DATA_W-1:0] wb_line;
  logic                             mem_valid;
  logic [WORDS_PER_LINE*DATA_W-1:0] fill_line;
  logic [ADDR_W-1:0]                mm_addr;
  logic [DATA_W-1:0]                mm_wdata;
  logic                             mm_re;
  logic                             mm_we;
  logic [DATA_W-1:0]                mm_rdata;
  logic                             mm_ack;

  modport master (
    input  mem_read, mem_write, line_addr, wb_line, mm_rdata, mm_ack,
    output mem_valid, fill_line, mm_addr, mm_wdata, mm_re, mm_we
  );

  modport slave (
    output mem_read, mem_write, line_addr, wb_line, mm_rdata, mm_ack,
    input  mem_valid, fill_line, mm_addr, mm_wdata, mm_re, mm_we
  );
endinterface

// File: rtl/cache_mem_burst_adapter.sv
// Converts line fill / write-back requests into in-order single-word bursts on
// the main-memory port, assembling fill lines and pulsing mem_valid per line.
module cache_mem_burst_adapter #(
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  cache_mem_burst_adapter_if.master bus
);
  localparam int BEAT_W = $clog2(WORDS_PER_LINE);
  localparam int OFF_W  = $clog2(WORDS_PER_LINE * DATA_W / 8);
  localparam int LINE_W = WORDS_PER_LINE * DATA_W;
  localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(DATA_W / 8);
  localparam logic [ADDR_W-1:0] OFF_MASK  = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, WB_BURST, FILL_BURST, DONE} state_t;

  state_t              state, state_nxt;
  logic [BEAT_W-1:0]   beat;
  logic [ADDR_W-1:0]   base;
  logic [DATA_W-1:0]   wb_words   [WORDS_PER_LINE];
  logic [DATA_W-1:0]   fill_words [WORDS_PER_LINE];
  logic [LINE_W-1:0]   fill_packed;
  logic                in_burst;
  logic                beat_done;
  logic                req_take;

  assign in_burst  = (state == WB_BURST) || (state == FILL_BURST);
  assign beat_done = in_burst && bus.mm_ack;
  assign req_take  = (state == IDLE) && (bus.mem_write || bus.mem_read);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE)
        beat <= '0;
      else if (beat_done)
        beat <= beat + 1'b1;  // power-of-2 line length: wraps to 0 after the last beat
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.mem_write)     state_nxt = WB_BURST;
        else if (bus.mem_read) state_nxt = FILL_BURST;
      end
      WB_BURST, FILL_BURST: begin
        if (bus.mm_ack && (beat == LAST_BEAT)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch: later changes on line_addr/wb_line cannot disturb a burst
  always_ff @(posedge clk) begin
    if (req_take) begin
      base <= bus.line_addr & OFF_MASK;
      if (bus.mem_write) begin
        for (int i = 0; i < WORDS_PER_LINE; i++)
          wb_words[i] <= bus.wb_line[i*DATA_W +: DATA_W];
      end
    end
  end

  // Fill assembly
  always_ff @(posedge clk) begin
    if (rst)
      fill_words <= '{default: '0};
    else if ((state == FILL_BURST) && bus.mm_ack)
      fill_words[beat] <= bus.mm_rdata;
  end

  always_comb begin
    fill_packed = '0;
    for (int i = 0; i < WORDS_PER_LINE; i++)
      fill_packed[i*DATA_W +: DATA_W] = fill_words[i];
  end

  assign bus.fill_line = fill_packed;
  assign bus.mm_re     = (state == FILL_BURST);
  assign bus.mm_we     = (state == WB_BURST);
  assign bus.mem_valid = (state == DONE);
  assign bus.mm_addr   = in_burst ? (base + ADDR_W'(beat) * STRIDE) : '0;
  assign bus.mm_wdata  = (state == WB_BURST) ? wb_words[beat] : '0;

endmodule
